// File: rtl/decodificador_eventos_ps2.sv
// decodificador_eventos_ps2: PS/2 frame checker, E0/F0 prefix decoder and show-ahead event FIFO
module decodificador_eventos_ps2 #(
  parameter int W = 2,
  parameter int TYPEMATIC_FILTER = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_done_tick,
  input  logic [10:0] rx_frame,
  input  logic        rd,
  input  logic        clr_err,
  output logic        ev_valid,
  output logic [7:0]  ev_code,
  output logic        ev_break,
  output logic        ev_ext,
  output logic        shift_held,
  output logic        overflow,
  output logic        frame_err
);
  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;
  state_t state, state_nx;
  logic [7:0] code;
  logic frame_ok, ext, brk, ignore, dec, emit, held_v, held_hit, sh_l, sh_r;
  logic [8:0] held_k, key;
  logic [W:0] wr_ptr, rd_ptr;
  logic full, empty, do_rd, do_wr;
  logic [9:0] mem [2**W];
  assign code = rx_frame[8:1];
  assign frame_ok = ~rx_frame[0] & rx_frame[10] & (^rx_frame[9:1]);
  always_comb begin
    state_nx = state;
    dec = 1'b0;
    ext = (state == GOT_E0) || (state == GOT_E0F0);
    brk = (state == GOT_F0) || (state == GOT_E0F0);
    ignore = (state == IDLE) && (code inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF});
    if (rx_done_tick) begin
      if (!frame_ok) state_nx = IDLE;
      else if (code == 8'hE0 && !brk) state_nx = GOT_E0;
      else if (code == 8'hF0) state_nx = ext ? GOT_E0F0 : GOT_F0;
      else if (!ignore) begin
        dec = 1'b1;
        state_nx = IDLE;
      end
    end
  end
  assign key = {ext, code};
  assign held_hit = held_v && (held_k == key);
  // typematic repeats of the held key are swallowed but still refresh held/shift state
  assign emit = dec && !((TYPEMATIC_FILTER != 0) && !brk && held_hit);
  assign empty = (wr_ptr == rd_ptr);
  assign full = ((wr_ptr ^ rd_ptr) == {1'b1, {W{1'b0}}});
  assign do_rd = rd && !empty;
  assign do_wr = emit && (!full || do_rd);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      held_v <= 1'b0;
      held_k <= '0;
      sh_l <= 1'b0;
      sh_r <= 1'b0;
      overflow <= 1'b0;
      frame_err <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_nx;
      if (dec && !brk) {held_v, held_k} <= {1'b1, key};
      else if (dec && held_hit) held_v <= 1'b0;
      if (dec && !ext && code == 8'h12) sh_l <= !brk;
      if (dec && !ext && code == 8'h59) sh_r <= !brk;
      frame_err <= (rx_done_tick && !frame_ok) | (frame_err & ~clr_err);
      overflow <= (emit && full && !do_rd) | (overflow & ~clr_err);
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk) if (do_wr) mem[wr_ptr[W-1:0]] <= {code, brk, ext};
  assign shift_held = sh_l | sh_r;
  assign ev_valid = !empty;
  assign {ev_code, ev_break, ev_ext} = ev_valid ? mem[rd_ptr[W-1:0]] : 10'd0;
endmodule

// File: tb/tb_decodificador_eventos_ps2.sv
// tb_decodificador_eventos_ps2: random and directed frames against a list-based reference model, filter on and off
module tb_decodificador_eventos_ps2;
  logic clk, reset, tick, rd, clr;
  logic [10:0] frame;
  logic ev_valid [2], ev_break [2], ev_ext [2], shift_held [2], overflow [2], frame_err [2];
  logic [7:0] ev_code [2];
  int checks = 0, errors = 0;
  bit pe [2], pb [2], hv [2], s12 [2], s59 [2], ovf [2], ferr [2];
  logic [8:0] hk [2];
  logic [9:0] fq [2][8];
  int n [2];
  logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h1C, 8'h75, 8'h15, 8'h00, 8'hAA, 8'hFF, 8'hE0, 8'hF0};

  decodificador_eventos_ps2 #(.W(2), .TYPEMATIC_FILTER(1)) u0 (
    .clk(clk), .reset(reset), .rx_done_tick(tick), .rx_frame(frame), .rd(rd), .clr_err(clr),
    .ev_valid(ev_valid[0]), .ev_code(ev_code[0]), .ev_break(ev_break[0]), .ev_ext(ev_ext[0]),
    .shift_held(shift_held[0]), .overflow(overflow[0]), .frame_err(frame_err[0]));
  decodificador_eventos_ps2 #(.W(2), .TYPEMATIC_FILTER(0)) u1 (
    .clk(clk), .reset(reset), .rx_done_tick(tick), .rx_frame(frame), .rd(rd), .clr_err(clr),
    .ev_valid(ev_valid[1]), .ev_code(ev_code[1]), .ev_break(ev_break[1]), .ev_ext(ev_ext[1]),
    .shift_held(shift_held[1]), .overflow(overflow[1]), .frame_err(frame_err[1]));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input int e);
    logic par = ~^d;
    if (e == 1) par = ~par;
    return {e != 2, par, d, e == 3};
  endfunction

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      pe[i] = 0; pb[i] = 0; hv[i] = 0; hk[i] = 0; s12[i] = 0; s59[i] = 0;
      ovf[i] = 0; ferr[i] = 0; n[i] = 0;
    end
  endtask

  // Reference: prefixes are remembered as two flags; the queue is a plain list shifted on pop
  task automatic step(input int i, input bit t, input logic [10:0] f, input bit r, input bit c);
    logic [7:0] d = f[8:1];
    bit ok = !f[0] && f[10] && ($countones(f[9:1]) % 2 == 1);
    bit pop = r && n[i] > 0;
    bit em = 0, fset = 0, oset = 0;
    logic [9:0] ev = 0;
    logic [8:0] k;
    if (t) begin
      if (!ok) begin fset = 1; pe[i] = 0; pb[i] = 0; end
      else if (d == 8'hE0 && !pb[i]) pe[i] = 1;
      else if (d == 8'hF0) pb[i] = 1;
      else if (!pe[i] && !pb[i] && (d == 8'h00 || d == 8'hAA || d == 8'hEE || d == 8'hFA || d == 8'hFE || d == 8'hFF)) ;
      else begin
        k = {pe[i], d};
        if (!pb[i]) begin
          em = !(i == 0 && hv[i] && hk[i] == k);
          hv[i] = 1; hk[i] = k;
        end else begin
          em = 1;
          if (hv[i] && hk[i] == k) hv[i] = 0;
        end
        if (!pe[i] && d == 8'h12) s12[i] = !pb[i];
        if (!pe[i] && d == 8'h59) s59[i] = !pb[i];
        ev = {d, pb[i], pe[i]};
        pe[i] = 0; pb[i] = 0;
      end
    end
    if (pop) begin
      for (int j = 0; j < 7; j++) fq[i][j] = fq[i][j+1];
      n[i]--;
    end
    if (em) begin
      if (n[i] < 4) begin fq[i][n[i]] = ev; n[i]++; end
      else oset = 1;
    end
    ferr[i] = fset | (ferr[i] & !c);
    ovf[i] = oset | (ovf[i] & !c);
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("valid%0d", i), ev_valid[i], n[i] > 0);
      if (n[i] > 0) chk($sformatf("head%0d", i), {ev_code[i], ev_break[i], ev_ext[i]}, fq[i][0]);
      chk($sformatf("shift%0d", i), shift_held[i], s12[i] | s59[i]);
      chk($sformatf("ovf%0d", i), overflow[i], ovf[i]);
      chk($sformatf("ferr%0d", i), frame_err[i], ferr[i]);
    end
  endtask

  task automatic cyc(input bit t, input logic [10:0] f, input bit r, input bit c);
    @(negedge clk);
    tick = t; frame = f; rd = r; clr = c;
    @(posedge clk);
    step(0, t, f, r, c);
    step(1, t, f, r, c);
    #1 compare();
  endtask

  task automatic send(input logic [7:0] d, input int e = 0);
    cyc(1, mk(d, e), 0, 0);
  endtask

  task automatic drain();
    repeat (6) cyc(0, 11'd0, 1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    tick = 0; rd = 0; clr = 0; reset = 1;
    mreset();
    #2 compare();
    chk("rst_code", ev_code[0], 0);
    chk("rst_brk_ext", {ev_break[0], ev_ext[0]}, 0);
    @(negedge clk) reset = 0;
  endtask

  initial begin
    tick = 0; rd = 0; clr = 0; frame = 0; reset = 0;
    do_reset();
    send(8'h1C);
    chk("lat1_valid", ev_valid[0], 1);
    send(8'hF0); send(8'h1C);
    drain();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    drain();
    foreach (pool[j]) if (j < 5) send(j == 0 ? 8'h15 : j == 1 ? 8'h1D : j == 2 ? 8'h24 : j == 3 ? 8'h2D : 8'h2C);
    chk("full_ovf", overflow[0], 1);
    cyc(1, mk(8'h1B, 0), 1, 0);
    chk("full_keep", ev_valid[0], 1);
    cyc(0, 11'd0, 0, 1);
    chk("clr_ovf", overflow[0], 0);
    drain();
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    drain();
    send(8'h33, 1); send(8'hE0, 2); send(8'h12);
    chk("perr_ferr", frame_err[0], 1);
    chk("perr_shift", shift_held[0], 1);
    send(8'hF0); send(8'h12);
    cyc(0, 11'd0, 0, 1);
    drain();
    send(8'hE0);
    do_reset();
    send(8'h75);
    chk("post_rst_ext", ev_ext[0], 0);
    drain();
    for (int k = 0; k < 3000; k++) begin
      int e = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 3) : 0;
      cyc($urandom_range(0, 1) == 1, mk(pool[$urandom_range(0, 11)], e),
          $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decodificador_eventos_ps2.md
DECODIFICADOR_EVENTOS_PS2 -- requirements
Module: decodificador_eventos_ps2

Interface
REQ-001 The block SHALL have parameter W, default 2, meaning event FIFO address bits (depth 2^W).
REQ-002 The block SHALL have parameter TYPEMATIC_FILTER, default 1, meaning 1 = suppress repeated make of an already-held key.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  system clock (all state on rising edge); reset  input  1  asynchronous active-high reset.
REQ-004 The block SHALL have the data ports: rx_done_tick  input  1  one-cycle strobe, frame valid; rx_frame  input  11  [0] start, [8:1] data LSB-first, [9] parity, [10] stop.
REQ-005 The block SHALL have the pop/error inputs: rd  input  1  pop head event; clr_err  input  1  clears sticky flags.
REQ-006 The block SHALL have the event outputs: ev_valid  output  1  FIFO not empty; ev_code  output  8  head scan code; ev_break  output  1  head is release; ev_ext  output  1  head carried E0 prefix.
REQ-007 The block SHALL have the status outputs: shift_held  output  1  left or right shift down; overflow  output  1  sticky, event dropped; frame_err  output  1  sticky, bad frame seen.

Function
REQ-008 A frame SHALL be valid only if start=0, stop=1 and data plus parity hold an odd count of ones.
REQ-009 An invalid frame SHALL be discarded, SHALL set frame_err and SHALL return the FSM to IDLE with no event emitted.
REQ-010 The prefix FSM SHALL have states IDLE, GOT_E0, GOT_F0 and GOT_E0F0, and SHALL advance only on cycles where rx_done_tick=1 and the frame is valid.
REQ-011 The FSM SHALL follow these transitions:
- IDLE: E0 -> GOT_E0; F0 -> GOT_F0.
- GOT_E0: F0 -> GOT_E0F0.
- Any other code emits an event and returns to IDLE.
REQ-012 The emitted event SHALL take ext=1 from GOT_E0 or GOT_E0F0 and break=1 from GOT_F0 or GOT_E0F0; otherwise both flags SHALL be 0.
REQ-013 In GOT_E0, a further E0 SHALL keep the FSM in GOT_E0, and a further F0 in GOT_F0 or GOT_E0F0 SHALL keep the FSM in the same state.
REQ-014 In IDLE, codes 00, AA, EE, FA, FE and FF SHALL be discarded with no event and no state change.
REQ-015 The held-key register {valid, ext, code} SHALL be loaded on every make and cleared on a break matching both ext and code.
REQ-016 With TYPEMATIC_FILTER=1, a make equal to the valid held key SHALL NOT be emitted; with TYPEMATIC_FILTER=0, every make SHALL be emitted.
REQ-017 shift_held SHALL be the OR of two flags, non-ext 12 and non-ext 59, each set on make and cleared on break, updated regardless of filtering.
REQ-018 An event SHALL be written at the clk edge that samples rx_done_tick=1 with the final code, and ev_valid SHALL be high in the cycle after that edge (latency 1).
REQ-019 The FIFO SHALL be show-ahead: ev_code, ev_break and ev_ext SHALL present the head whenever ev_valid=1 and SHALL be don't-care otherwise.
REQ-020 rd while empty SHALL be ignored with no pointer change.
REQ-021 A write while full without rd SHALL drop the new event, keep the FIFO contents and set overflow.
REQ-022 Simultaneous rd and write when full SHALL both succeed, with occupancy unchanged and no overflow.
REQ-023 Simultaneous rd and write when empty SHALL perform only the write.
REQ-024 The FIFO pointers SHALL wrap modulo 2^W, and the full and empty states SHALL be distinguished by an extra pointer bit or an occupancy count.
REQ-025 clr_err SHALL clear overflow and frame_err in the next cycle, and a set condition in the same cycle SHALL win.

Reset
REQ-026 Reset SHALL asynchronously force: FSM=IDLE; FIFO empty (ev_valid=0); held-key invalid; shift flags 0; overflow=0; frame_err=0; ev_code=00; ev_break=0; ev_ext=0.
REQ-027 Reset asserted mid-sequence (e.g. after E0) SHALL discard the partial prefix, and the first frame after release SHALL be decoded from IDLE.

Verification
REQ-028 Frames 1C, F0, 1C -> events {1C, brk0, ext0} then {1C, brk1, ext0}, each ev_valid 1 cycle after its tick.
REQ-029 Frames E0, 75, E0, F0, 75 -> {75, 0, 1} then {75, 1, 1}, FSM back in IDLE.
REQ-030 With W=2, 5 makes 15, 1D, 24, 2D, 2C and no rd -> 4 events held, fifth dropped, overflow=1; rd plus a new make while full -> occupancy stays 4.
REQ-031 With TYPEMATIC_FILTER=1, frames 1C, 1C, 1C, F0, 1C -> exactly two events (make, break); with 0 -> four events.
REQ-032 Frame with a parity error, then E0 with stop=0, then 12 -> frame_err=1, one event {12, 0, 0}, shift_held=1.
REQ-033 Reset pulse between E0 and 75, then frame 75 -> event {75, 0, 0}, all flags 0.
